// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared widths, job record and dispatcher states for the MVM command queue
package mvm_pkg;

    localparam int VEC_ADDRW = 8;
    localparam int MAT_ADDRW = 9;
    localparam int VEC_SIZEW = VEC_ADDRW + 1;
    localparam int MAT_SIZEW = MAT_ADDRW + 1;

    typedef struct packed {
        logic [VEC_ADDRW-1:0] vec_start_addr;
        logic [VEC_SIZEW-1:0] vec_num_words;
        logic [MAT_ADDRW-1:0] mat_start_addr;
        logic [MAT_SIZEW-1:0] mat_num_rows;
    } mvm_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        DRAIN
    } disp_state_e;

    // A job with no vector words or no matrix rows has nothing for the controller to do
    function automatic logic cmd_is_zero(input mvm_cmd_t c);
        return (c.vec_num_words == '0) || (c.mat_num_rows == '0);
    endfunction

endpackage

// File: rtl/mvm_cmd_fifo.sv
// rtl/mvm_cmd_fifo.sv - synchronous FIFO of MVM job records with flush
import mvm_pkg::*;

module mvm_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  mvm_cmd_t                 wr_data,
    output mvm_cmd_t                 rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    mvm_cmd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); flush discards everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mvm_cmd_queue.sv
// rtl/mvm_cmd_queue.sv - job queue and one-at-a-time dispatcher in front of the MVM controller
import mvm_pkg::*;

module mvm_cmd_queue #(
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 4,
    parameter int DRAIN_CYCLES = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [VEC_ADDRW-1:0]   cmd_vec_start_addr,
    input  logic [VEC_SIZEW-1:0]   cmd_vec_num_words,
    input  logic [MAT_ADDRW-1:0]   cmd_mat_start_addr,
    input  logic [MAT_SIZEW-1:0]   cmd_mat_num_rows,
    input  logic                   flush,
    input  logic                   err_clr,
    output logic                   ctrl_start,
    output logic [VEC_ADDRW-1:0]   ctrl_vec_start_addr,
    output logic [VEC_SIZEW-1:0]   ctrl_vec_num_words,
    output logic [MAT_ADDRW-1:0]   ctrl_mat_start_addr,
    output logic [MAT_SIZEW-1:0]   ctrl_mat_num_rows,
    input  logic                   ctrl_busy,
    output logic [$clog2(DEPTH):0] q_level,
    output logic                   active,
    output logic                   cmd_done,
    output logic [15:0]            done_count,
    output logic                   err_zero,
    output logic                   err_timeout
);

    // Both waits count cycles from the triggering event (start pulse / busy fall) as cycle 0,
    // so the exit edge is the one closing cycle N-1 and the result shows in cycle N.
    localparam logic [15:0] BUSY_LAST  = 16'(BUSY_TIMEOUT - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    disp_state_e state;
    disp_state_e state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic        timeout_hit;
    logic        job_done;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        zero_job;
    logic        push;
    logic        pop;
    mvm_cmd_t    in_cmd;
    mvm_cmd_t    head_cmd;

    assign in_cmd = '{vec_start_addr: cmd_vec_start_addr,
                      vec_num_words:  cmd_vec_num_words,
                      mat_start_addr: cmd_mat_start_addr,
                      mat_num_rows:   cmd_mat_num_rows};

    // Ready follows the registered fill level only; held low while in reset
    assign cmd_ready = rst_n && !fifo_full;
    assign accept    = cmd_valid && cmd_ready;
    assign zero_job  = cmd_is_zero(in_cmd);
    assign push      = accept && !zero_job && !flush;
    assign pop       = (state == IDLE) && !fifo_empty && !flush;

    mvm_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (in_cmd),
        .rd_data (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (q_level)
    );

    // Dispatcher state and shared wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state decode; busy is checked before the timeout so a late-but-valid busy still wins
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        timeout_hit = 1'b0;
        job_done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pop) state_next = ISSUE;
            end
            ISSUE: begin
                state_next = WAIT_BUSY;
                cnt_next   = 16'd1;
            end
            WAIT_BUSY: begin
                if (ctrl_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt >= BUSY_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (!ctrl_busy) begin
                    if (DRAIN_CYCLES > 1) begin
                        state_next = DRAIN;
                        cnt_next   = 16'd1;
                    end else begin
                        job_done   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (cnt >= DRAIN_LAST) begin
                    job_done   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs: operand capture at pop, pulses, completion count and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_start          <= 1'b0;
            ctrl_vec_start_addr <= '0;
            ctrl_vec_num_words  <= '0;
            ctrl_mat_start_addr <= '0;
            ctrl_mat_num_rows   <= '0;
            active              <= 1'b0;
            cmd_done            <= 1'b0;
            done_count          <= '0;
            err_zero            <= 1'b0;
            err_timeout         <= 1'b0;
        end else begin
            ctrl_start <= pop;
            if (pop) begin
                ctrl_vec_start_addr <= head_cmd.vec_start_addr;
                ctrl_vec_num_words  <= head_cmd.vec_num_words;
                ctrl_mat_start_addr <= head_cmd.mat_start_addr;
                ctrl_mat_num_rows   <= head_cmd.mat_num_rows;
            end
            active   <= (state_next != IDLE);
            cmd_done <= job_done;
            if (job_done) done_count <= done_count + 16'd1;
            if (accept && zero_job) err_zero <= 1'b1;
            else if (err_clr)       err_zero <= 1'b0;
            if (timeout_hit)        err_timeout <= 1'b1;
            else if (err_clr)       err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mvm_cmd_queue.sv
// tb/tb_mvm_cmd_queue.sv - self-checking bench for mvm_cmd_queue
module tb_mvm_cmd_queue;
    import mvm_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [VEC_ADDRW-1:0] cmd_vec_start_addr = '0;
    logic [VEC_SIZEW-1:0] cmd_vec_num_words = '0;
    logic [MAT_ADDRW-1:0] cmd_mat_start_addr = '0;
    logic [MAT_SIZEW-1:0] cmd_mat_num_rows = '0;
    logic                 flush = 1'b0;
    logic                 err_clr = 1'b0;
    logic                 ctrl_start;
    logic [VEC_ADDRW-1:0] ctrl_vec_start_addr;
    logic [VEC_SIZEW-1:0] ctrl_vec_num_words;
    logic [MAT_ADDRW-1:0] ctrl_mat_start_addr;
    logic [MAT_SIZEW-1:0] ctrl_mat_num_rows;
    logic                 ctrl_busy = 1'b0;
    logic [2:0]           q_level;
    logic                 active;
    logic                 cmd_done;
    logic [15:0]          done_count;
    logic                 err_zero;
    logic                 err_timeout;

    mvm_cmd_queue dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_vec_start_addr(cmd_vec_start_addr), .cmd_vec_num_words(cmd_vec_num_words),
        .cmd_mat_start_addr(cmd_mat_start_addr), .cmd_mat_num_rows(cmd_mat_num_rows),
        .flush(flush), .err_clr(err_clr), .ctrl_start(ctrl_start),
        .ctrl_vec_start_addr(ctrl_vec_start_addr), .ctrl_vec_num_words(ctrl_vec_num_words),
        .ctrl_mat_start_addr(ctrl_mat_start_addr), .ctrl_mat_num_rows(ctrl_mat_num_rows),
        .ctrl_busy(ctrl_busy), .q_level(q_level), .active(active), .cmd_done(cmd_done),
        .done_count(done_count), .err_zero(err_zero), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: jobs the controller must receive, in acceptance order, and completions seen
    mvm_cmd_t exp_q[$];
    mvm_cmd_t mon_exp;
    int       exp_done = 0;
    int       fall_cyc = -100;
    int       last_start_cyc = -100;
    int       last_done_cyc = -100;
    logic     prev_busy = 1'b0;
    logic     prev_start = 1'b0;

    // Controller model: busy rises d cycles after start, holds h cycles (or until stall released)
    bit bm_never = 1'b0;
    bit bm_stall = 1'b0;
    bit bm_rand = 1'b0;
    int bm_d;
    int bm_h;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ctrl_start && !bm_never) begin
                bm_d = bm_rand ? int'($urandom_range(1, 3)) : 2;
                bm_h = bm_rand ? int'($urandom_range(1, 6)) : 8;
                repeat (bm_d) @(posedge clk);
                #1 ctrl_busy = 1'b1;
                repeat (bm_h) @(posedge clk);
                while (bm_stall) @(posedge clk);
                #1 ctrl_busy = 1'b0;
            end
        end
    end

    // Monitor: issue order/operands, single-cycle start, spacing after done, drain latency
    initial begin
        forever begin
            tick();
            if (rst_n) begin
                if (prev_busy && !ctrl_busy) fall_cyc = cyc;
                if (ctrl_start) begin
                    last_start_cyc = cyc;
                    chk("start_single_cycle", prev_start, 1'b0);
                    chk("start_after_done", cyc > last_done_cyc, 1'b1);
                    if (exp_q.size() == 0) begin
                        chk("start_unexpected", 1'b1, 1'b0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("ctrl_operands",
                            {ctrl_vec_start_addr, ctrl_vec_num_words, ctrl_mat_start_addr, ctrl_mat_num_rows},
                            mon_exp);
                    end
                end
                if (cmd_done) begin
                    exp_done++;
                    last_done_cyc = cyc;
                    chk("done_count_step", done_count, 16'(exp_done));
                    chk("done_latency", cyc - fall_cyc, 11);
                end
                prev_start = ctrl_start;
                prev_busy  = ctrl_busy;
            end else begin
                prev_start = 1'b0;
                prev_busy  = 1'b0;
            end
        end
    end

    task automatic push_job(input mvm_cmd_t c, input bit clr_with);
        int t = 0;
        cmd_vec_start_addr = c.vec_start_addr;
        cmd_vec_num_words  = c.vec_num_words;
        cmd_mat_start_addr = c.mat_start_addr;
        cmd_mat_num_rows   = c.mat_num_rows;
        cmd_valid = 1'b1;
        err_clr   = clr_with;
        while (!cmd_ready && t < 500) begin
            tick();
            t++;
        end
        if (!cmd_ready) begin
            chk("push_ready_timeout", 1'b0, 1'b1);
        end else begin
            @(posedge clk);
            if (c.vec_num_words != 0 && c.mat_num_rows != 0 && !flush) exp_q.push_back(c);
        end
        #2;
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || active) && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) chk({name, "_idle_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic wait_busy(input logic lvl);
        int t = 0;
        while (ctrl_busy !== lvl && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) chk("busy_wait_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        flush = 1'b0;
        err_clr = 1'b0;
        bm_never = 1'b0;
        bm_stall = 1'b0;
        bm_rand = 1'b0;
        repeat (2) tick();
        if (check) begin
            chk("reset_cmd_ready", cmd_ready, 1'b0);
            chk("reset_flags", {ctrl_start, active, cmd_done, err_zero, err_timeout}, 5'b0);
            chk("reset_done_count", done_count, 16'd0);
        end
        exp_q.delete();
        exp_done = 0;
        rst_n = 1'b1;
        tick();
        if (check) begin
            chk("ready_after_reset", cmd_ready, 1'b1);
            chk("level_after_reset", q_level, 3'd0);
        end
    endtask

    function automatic mvm_cmd_t mk(input logic [7:0] va, input logic [8:0] nw,
                                    input logic [8:0] ma, input logic [9:0] nr);
        mvm_cmd_t c;
        c.vec_start_addr = va;
        c.vec_num_words  = nw;
        c.mat_start_addr = ma;
        c.mat_num_rows   = nr;
        return c;
    endfunction

    // clr: 0 none, 1 err_clr pulsed before the push, 2 err_clr held during the push
    typedef struct {
        mvm_cmd_t cmd;
        int       clr;
        bit       exp_err;
        int       exp_done;
    } vec_t;
    vec_t tv[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        bit zs;
        mvm_cmd_t c;

        tv[0] = '{mk(8'h00, 9'd4,   9'h000, 10'd2),    0, 1'b0, 1};
        tv[1] = '{mk(8'hFF, 9'd256, 9'h1FF, 10'd512),  0, 1'b0, 2};
        tv[2] = '{mk(8'h10, 9'd0,   9'h020, 10'd3),    0, 1'b1, 2};
        tv[3] = '{mk(8'h20, 9'd5,   9'h030, 10'd1),    0, 1'b1, 3};
        tv[4] = '{mk(8'h30, 9'd7,   9'h040, 10'd0),    0, 1'b1, 3};
        tv[5] = '{mk(8'h40, 9'd1,   9'h041, 10'd1),    1, 1'b0, 4};
        tv[6] = '{mk(8'h50, 9'd0,   9'h050, 10'd2),    2, 1'b1, 4};
        tv[7] = '{mk(8'h60, 9'd511, 9'h0AA, 10'd1023), 1, 1'b0, 5};

        do_reset(1'b1);

        // Table: single jobs, zero-size drops, sticky error clear, clear-vs-set priority
        for (int i = 0; i < 8; i++) begin
            if (tv[i].clr == 1) begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
            end
            push_job(tv[i].cmd, tv[i].clr == 2);
            if (tv[i].cmd.vec_num_words != 0 && tv[i].cmd.mat_num_rows != 0) begin
                chk("start_latency_early", ctrl_start, 1'b0);
                tick();
                chk("start_latency", ctrl_start, 1'b1);
            end
            wait_idle("table");
            chk("table_err_zero", err_zero, tv[i].exp_err);
            chk("table_done_count", done_count, 16'(tv[i].exp_done));
        end

        // Back-pressure: controller stalled on job 1 while four more fill the queue
        do_reset(1'b0);
        bm_stall = 1'b1;
        for (int i = 0; i < 5; i++) push_job(mk(8'(i * 3), 9'(i + 1), 9'(i * 7), 10'(i + 2)), 1'b0);
        tick();
        chk("full_level", q_level, 3'd4);
        chk("full_not_ready", cmd_ready, 1'b0);
        bm_stall = 1'b0;
        wait_idle("backpressure");
        chk("backpressure_done_count", done_count, 16'd5);

        // Busy never arrives: timeout flag 4 cycles after start, no completion, next job runs
        do_reset(1'b0);
        bm_never = 1'b1;
        push_job(mk(8'h11, 9'd3, 9'h022, 10'd4), 1'b0);
        begin
            int t = 0;
            while (!err_timeout && t < 50) begin
                tick();
                t++;
            end
        end
        chk("timeout_latency", cyc - last_start_cyc, 4);
        repeat (5) tick();
        chk("timeout_no_done", done_count, 16'd0);
        chk("timeout_idle", active, 1'b0);
        bm_never = 1'b0;
        push_job(mk(8'h12, 9'd2, 9'h023, 10'd1), 1'b0);
        wait_idle("after_timeout");
        chk("after_timeout_done", done_count, 16'd1);
        chk("timeout_sticky", err_timeout, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("timeout_cleared", err_timeout, 1'b0);

        // Flush while job 1 is in WAIT_DONE: queued jobs vanish, job 1 still completes
        do_reset(1'b0);
        bm_stall = 1'b1;
        for (int i = 0; i < 3; i++) push_job(mk(8'(8'h70 + i), 9'd6, 9'(9'h100 + i), 10'd3), 1'b0);
        wait_busy(1'b1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        chk("flush_level", q_level, 3'd0);
        chk("flush_keeps_job", active, 1'b1);
        bm_stall = 1'b0;
        wait_idle("flush");
        repeat (20) tick();
        chk("flush_done_count", done_count, 16'd1);
        chk("flush_stays_idle", active, 1'b0);

        // Asynchronous reset during DRAIN, then normal operation
        do_reset(1'b0);
        push_job(mk(8'h01, 9'd4, 9'h002, 10'd2), 1'b0);
        wait_idle("pre_reset");
        push_job(mk(8'h03, 9'd5, 9'h004, 10'd6), 1'b0);
        wait_busy(1'b1);
        wait_busy(1'b0);
        repeat (3) tick();
        chk("in_drain_active", active, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {cmd_ready, ctrl_start, active, cmd_done, err_zero, err_timeout}, 6'b0);
        chk("async_rst_count", {done_count, 5'(q_level)}, 21'd0);
        chk("async_rst_operands",
            {ctrl_vec_start_addr, ctrl_vec_num_words, ctrl_mat_start_addr, ctrl_mat_num_rows}, 36'd0);
        repeat (2) tick();
        exp_q.delete();
        exp_done = 0;
        rst_n = 1'b1;
        tick();
        push_job(mk(8'h05, 9'd2, 9'h006, 10'd2), 1'b0);
        wait_idle("post_reset");
        chk("post_reset_done", done_count, 16'd1);

        // Randomized jobs and gaps against the queue model, random controller timing
        do_reset(1'b0);
        bm_rand = 1'b1;
        nz = 0;
        zs = 1'b0;
        for (int i = 0; i < 40; i++) begin
            c = mk(8'($urandom), 9'($urandom_range(1, 511)), 9'($urandom), 10'($urandom_range(1, 1023)));
            if ($urandom_range(0, 5) == 0) c.vec_num_words = '0;
            if ($urandom_range(0, 5) == 0) c.mat_num_rows = '0;
            push_job(c, 1'b0);
            if (c.vec_num_words != 0 && c.mat_num_rows != 0) nz++;
            else zs = 1'b1;
            repeat ($urandom_range(0, 8)) tick();
        end
        wait_idle("random");
        chk("random_done_count", done_count, 16'(nz));
        chk("random_err_zero", err_zero, zs);
        chk("random_no_timeout", err_timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
